// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on device clock falls, ACK check.
// Drives the open-drain PS/2 pads low only; a released line reads high via the pull-up.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_START = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          state_q;
  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_prev_q;
  logic [9:0]      frame_q;
  logic [3:0]      bit_cnt_q;
  logic [CW-1:0]   cnt_q;
  logic            clk_low_q, data_low_q, busy_q, done_q, err_q;
  logic            clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;

  // Synchronizers reset to the idle (pulled-up) line level so no false fall follows reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clock_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_s;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // the async reset also releases both pads immediately, even mid-frame.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            frame_q    <= {1'b1, ~^tx_data, tx_data};
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            clk_low_q  <= 1'b1;
            data_low_q <= 1'b0;
            state_q    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == INH_START) data_low_q <= 1'b1;
          if (cnt_q == INH_LAST) begin
            clk_low_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_SEND;
          end
        end
        default: begin
          cnt_q <= cnt_q + 1'b1;
          // Timeout wins over a fall arriving in the same cycle.
          if (cnt_q == TO_LAST) begin
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end else if (state_q == S_SEND) begin
            if (fall) begin
              data_low_q <= ~frame_q[0];
              frame_q    <= {1'b0, frame_q[9:1]};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 4'd9) state_q <= S_ACK;
            end
          end else if (state_q == S_ACK) begin
            if (fall) begin
              if (data_s) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_WAIT_IDLE;
              end
            end
          end else if (clk_s && data_s) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ps2_clock_drive_low = clk_low_q;
  assign ps2_data_drive_low  = data_low_q;
  assign busy                = busy_q;
  assign tx_done             = done_q;
  assign tx_error            = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, behavioural keyboard, table of transfers,
// plus hand-written timeout, mid-frame reset and busy-start sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int IC = 40;
  localparam int TO = 3000;
  localparam int HP = 20;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clock_in, ps2_data_in;
  logic       ps2_clock_drive_low, ps2_data_drive_low, busy, tx_done, tx_error;

  assign ps2_clock_in = dev_clk & ~ps2_clock_drive_low;
  assign ps2_data_in  = dev_data & ~ps2_data_drive_low;

  ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TO)) dut (
    .clock               (clock),
    .resetn              (resetn),
    .tx_data             (tx_data),
    .tx_start            (tx_start),
    .ps2_clock_in        (ps2_clock_in),
    .ps2_data_in         (ps2_data_in),
    .ps2_clock_drive_low (ps2_clock_drive_low),
    .ps2_data_drive_low  (ps2_data_drive_low),
    .busy                (busy),
    .tx_done             (tx_done),
    .tx_error            (tx_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         inject;
    bit         hold_end;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];
  logic exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetn && (tx_done || tx_error)) begin
      check("pulse_busy_low", busy, 0);
      check("busy_before_pulse", busy_prev, 1);
      check("done_err_exclusive", tx_done & tx_error, 0);
    end
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
    busy_prev = busy;
  end

  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(($countones(d) % 2) == 0);
    exp_q.push_back(1'b1);
  endtask

  task automatic start_inhibit(input logic [7:0] d);
    int n = 0;
    int dcount = 0;
    int dlast = -1;
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    check("busy_on_accept", busy, 1);
    check("clk_low_on_accept", ps2_clock_drive_low, 1);
    while (ps2_clock_drive_low && n < IC + 10) begin
      if (ps2_data_drive_low) begin
        dcount++;
        dlast = n;
      end
      n++;
      @(negedge clock);
    end
    check("inhibit_len", n, IC);
    check("start_bit_cycles", dcount, 1);
    check("start_bit_pos", dlast, IC - 1);
    check("start_bit_held", ps2_data_drive_low, 1);
  endtask

  task automatic do_xfer(input vec_t v);
    int   d0 = done_cnt;
    int   e0 = err_cnt;
    int   n = 0;
    logic exp_bit;
    push_frame(v.data);
    start_inhibit(v.data);
    repeat (HP) @(negedge clock);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (k == v.inject) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        repeat (HP - 1) @(negedge clock);
      end else begin
        repeat (HP) @(negedge clock);
      end
      exp_bit = exp_q.pop_front();
      check($sformatf("bit%0d_of_%02h", k, v.data), ps2_data_in, exp_bit);
      check("busy_mid_frame", busy, 1);
      dev_clk = 1'b1;
      if (k == 10 && v.ack) dev_data = 1'b0;
      repeat (HP) @(negedge clock);
    end
    dev_clk = 1'b0;
    repeat (HP) @(negedge clock);
    dev_clk = 1'b1;
    repeat (HP) @(negedge clock);
    dev_data = 1'b1;
    if (v.hold_end) begin
      tx_data  = 8'h55;
      tx_start = 1'b1;
    end
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    tx_start = 1'b0;
    check("busy_drop_bound", busy, 0);
    @(negedge clock);
    check("no_restart", busy, 0);
    check($sformatf("done_count_%02h", v.data), done_cnt - d0, v.exp_done);
    check($sformatf("err_count_%02h", v.data), err_cnt - e0, v.exp_err);
    check("clk_released", ps2_clock_drive_low, 0);
    check("data_released", ps2_data_drive_low, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   e0;
    vec_t vf;
    vecs[0] = '{8'hED, 1, 0, 0, 1, 0};
    vecs[1] = '{8'h01, 1, 0, 0, 1, 0};
    vecs[2] = '{8'hFF, 0, 0, 0, 0, 1};
    vecs[3] = '{8'h00, 1, 0, 0, 1, 0};
    vecs[4] = '{8'h80, 1, 0, 0, 1, 0};
    vecs[5] = '{8'hED, 1, 5, 1, 1, 0};

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_clk_drv", ps2_clock_drive_low, 0);
    check("rst_data_drv", ps2_data_drive_low, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", tx_done | tx_error, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // Falls while idle must not start anything.
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      repeat (5) @(negedge clock);
      dev_clk = 1'b1;
      repeat (5) @(negedge clock);
    end
    check("idle_fall_busy", busy, 0);
    check("idle_fall_clk", ps2_clock_drive_low, 0);
    check("idle_fall_data", ps2_data_drive_low, 0);

    for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

    // Silent device: error exactly TO cycles after clock release.
    e0 = err_cnt;
    start_inhibit(8'h3C);
    idx = 0;
    while (!tx_error && idx < TO + 100) begin
      @(negedge clock);
      idx++;
    end
    check("timeout_cycles", idx, TO);
    check("timeout_busy", busy, 0);
    check("timeout_clk_rel", ps2_clock_drive_low, 0);
    check("timeout_data_rel", ps2_data_drive_low, 0);
    @(negedge clock);
    check("timeout_err_count", err_cnt - e0, 1);

    // Reset after fall 4 of 0xA5 (bit 3 = 0, so data is being pulled low).
    start_inhibit(8'hA5);
    repeat (HP) @(negedge clock);
    for (int k = 1; k <= 3; k++) begin
      dev_clk = 1'b0;
      repeat (HP) @(negedge clock);
      dev_clk = 1'b1;
      repeat (HP) @(negedge clock);
    end
    dev_clk = 1'b0;
    repeat (6) @(negedge clock);
    check("bit3_driven_low", ps2_data_drive_low, 1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_clk_rel", ps2_clock_drive_low, 0);
    check("midrst_data_rel", ps2_data_drive_low, 0);
    check("midrst_busy", busy, 0);
    dev_clk = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    vf = '{8'hF4, 1, 0, 0, 1, 0};
    do_xfer(vf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
